// File: rtl/mux4_scan_ctrl.sv
// mux4_scan_ctrl: steps the 4:1 mux select through enabled channels, samples Y after a settle
// interval and delivers the packed 4-bit frame over a VALID/READY handshake.
module mux4_scan_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] MASK,
  input  logic       Y,
  output logic       S1,
  output logic       S0,
  output logic [3:0] DATA,
  output logic       VALID,
  input  logic       READY,
  output logic       BUSY,
  output logic [7:0] FRAME_CNT
);
  typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_t;
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);
  state_t state;
  logic [1:0] sel;
  logic [7:0] cnt;
  logic [3:0] mask_q, shadow, higher, smp;
  logic start;
  function automatic logic [1:0] lowest(input logic [3:0] m);
    return m[0] ? 2'd0 : m[1] ? 2'd1 : m[2] ? 2'd2 : 2'd3;
  endfunction
  always_comb begin
    higher = mask_q & (4'b1110 << sel);
    smp = shadow | ((4'b0001 << sel) & {4{Y}});
    start = EN && MASK != 4'b0 && (state == IDLE || (state == OUT && READY));
  end
  assign {S1, S0} = sel;
  assign BUSY = state != IDLE;
  // a start overrides the OUT->IDLE move so back-to-back frames have no bubble
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      sel <= 2'd0;
      cnt <= 8'd0;
      mask_q <= 4'd0;
      shadow <= 4'd0;
      DATA <= 4'd0;
      VALID <= 1'b0;
      FRAME_CNT <= 8'd0;
    end else begin
      if (state == OUT && READY) begin
        VALID <= 1'b0;
        FRAME_CNT <= FRAME_CNT + 8'd1;
        state <= IDLE;
      end
      if (start) begin
        mask_q <= MASK;
        shadow <= 4'd0;
        sel <= lowest(MASK);
        cnt <= RELOAD;
        state <= SETTLE;
      end else if (state == SETTLE) begin
        if (cnt != 8'd0) cnt <= cnt - 8'd1;
        else begin
          shadow <= smp;
          if (higher != 4'd0) begin
            sel <= lowest(higher);
            cnt <= RELOAD;
          end else begin
            DATA <= smp;
            VALID <= 1'b1;
            state <= OUT;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// tb_mux4_scan_ctrl: directed scenarios plus a randomized scoreboard run against a frame-level model.
module tb_mux4_scan_ctrl;
  localparam int SC = 2;
  logic CLK, RST, EN, Y, READY, S1, S0, VALID, BUSY;
  logic [3:0] MASK, DATA, abcd;
  logic [7:0] FRAME_CNT;
  int vecs = 0, errs = 0, cyc = 0;
  logic [7:0] acc = 0;
  logic mon_on = 0, prev_v = 0;
  logic [3:0] last_data = 0, fm;
  typedef struct {logic [3:0] data; logic [3:0] mask; int lat; int start;} item_t;
  item_t exp_q[$];
  item_t cur;

  mux4_scan_ctrl #(.SETTLE_CYCLES(SC)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MASK(MASK), .Y(Y), .S1(S1), .S0(S0),
    .DATA(DATA), .VALID(VALID), .READY(READY), .BUSY(BUSY), .FRAME_CNT(FRAME_CNT)
  );

  // behavioural 4:1 mux: bit i of abcd is channel i (A=0 .. D=3)
  assign Y = abcd[{S1, S0}];

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  function automatic int popc(input logic [3:0] m);
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(m[i]);
    return n;
  endfunction

  always @(posedge CLK) begin
    cyc++;
    if (mon_on && VALID && READY) acc++;
  end

  always @(negedge CLK) begin
    if (mon_on) begin
      if (VALID && !prev_v) begin
        if (exp_q.size() == 0) begin
          vecs++;
          errs++;
          $display("FAIL sb_unexpected: got VALID with DATA %0h, required no frame pending", DATA);
        end else begin
          cur = exp_q.pop_front();
          chk("sb_data", 32'(DATA), 32'(cur.data));
          chk("sb_latency", cyc - cur.start, cur.lat);
          last_data = cur.data;
        end
      end else if (VALID) chk("sb_hold", 32'(DATA), 32'(last_data));
      else if (BUSY && exp_q.size() > 0) begin
        fm = exp_q[0].mask;
        chk("sb_sel_enabled", 32'(fm[{S1, S0}]), 32'd1);
      end
      chk("sb_frame_cnt", 32'(FRAME_CNT), 32'(acc));
      prev_v = VALID;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic [3:0] m, v;
    RST = 1; EN = 0; MASK = 0; READY = 0; abcd = 0;
    repeat (2) tick();
    chk("reset", 32'({S1, S0, DATA, VALID, BUSY, FRAME_CNT}), 32'd0);
    // basic frame, all channels
    RST = 0; abcd = 4'b0101; MASK = 4'b1111; EN = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("t1_sel", 32'({VALID, S1, S0}), 32'({1'b0, 2'(i / 2)}));
    end
    tick();
    chk("t1_valid", 32'({VALID, DATA}), 32'({1'b1, 4'b0101}));
    READY = 1;
    tick();
    chk("t1_accept", 32'({VALID, BUSY, S1, S0, FRAME_CNT}), 32'({1'b0, 1'b1, 2'b00, 8'd1}));
    READY = 0; EN = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t1_next_latency", 32'(VALID), 32'(i == 8));
    end
    // backpressure
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold", 32'({VALID, DATA, S1, S0, FRAME_CNT}), 32'({1'b1, 4'b0101, 2'b11, 8'd1}));
    end
    READY = 1;
    tick();
    chk("t3_accept", 32'({VALID, BUSY, FRAME_CNT}), 32'({1'b0, 1'b0, 8'd2}));
    READY = 0;
    tick();
    chk("t3_single", 32'(FRAME_CNT), 32'd2);
    // masked scan
    MASK = 4'b1010; abcd = 4'b0101; EN = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_sel", 32'({VALID, S1, S0}), 32'({1'b0, (i < 2) ? 2'b01 : 2'b11}));
    end
    tick();
    chk("t2_data0", 32'({VALID, DATA}), 32'({1'b1, 4'b0000}));
    abcd = 4'b1101; READY = 1;
    tick();
    READY = 0;
    chk("t2_cnt", 32'(FRAME_CNT), 32'd3);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_latency", 32'(VALID), 32'(i == 4));
    end
    chk("t2_data1", 32'(DATA), 32'(4'b1000));
    READY = 1; EN = 0;
    tick();
    READY = 0;
    chk("t2_idle", 32'({BUSY, FRAME_CNT}), 32'({1'b0, 8'd4}));
    // sample timing: change one cycle before the sampling edge is captured
    MASK = 4'b0100; abcd = 4'b0000; EN = 1;
    tick();
    tick();
    abcd = 4'b0100;
    tick();
    chk("t4_before", 32'({VALID, DATA}), 32'({1'b1, 4'b0100}));
    // change right after the ch2 sampling edge is not captured
    READY = 1; MASK = 4'b1100; abcd = 4'b0100;
    tick();
    READY = 0;
    chk("t4_cnt", 32'(FRAME_CNT), 32'd5);
    tick();
    tick();
    abcd = 4'b0000;
    tick();
    tick();
    chk("t4_after", 32'({VALID, DATA}), 32'({1'b1, 4'b0100}));
    READY = 1; EN = 0;
    tick();
    READY = 0;
    chk("t4_idle", 32'({BUSY, FRAME_CNT}), 32'({1'b0, 8'd6}));
    // reset mid-settle
    MASK = 4'b1111; abcd = 4'b1111; EN = 1;
    repeat (3) tick();
    RST = 1;
    tick();
    chk("t5_reset", 32'({S1, S0, DATA, VALID, BUSY, FRAME_CNT}), 32'd0);
    RST = 0; EN = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t5_no_valid", 32'(VALID), 32'd0);
    end
    MASK = 4'b0000; EN = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_mask0_busy", 32'(BUSY), 32'd0);
    end
    // randomized back-to-back frames through the FRAME_CNT wrap
    mon_on = 1;
    tick();
    for (int k = 0; k < 300; k++) begin
      m = 4'($urandom_range(1, 15));
      v = 4'($urandom);
      MASK = m; abcd = v; READY = 1;
      exp_q.push_back('{data: v & m, mask: m, lat: popc(m) * SC, start: cyc + 1});
      tick();
      READY = 0;
      n = 0;
      while (!VALID && n < 100) begin
        tick();
        n++;
      end
      if (n == 100) begin
        vecs++;
        errs++;
        $display("FAIL rand_timeout: VALID 0 after %0d cycles, required 1", n);
        break;
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    READY = 1; EN = 0;
    tick();
    READY = 0;
    repeat (2) tick();
    mon_on = 0;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("wrap_final_cnt", 32'(FRAME_CNT), 32'(8'(300)));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
